// File: rtl/dmem_pkg.sv
// Shared types for the multi-cycle data-memory responder: FSM states,
// operation encoding and the latency counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int CNT_W = 4;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 2**ADDR_W x 32 storage: clocked write, combinational read,
// no reset so contents survive a responder reset.
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];

    // Commit a write on the rising edge when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder that stalls the pipeline for LATENCY cycles.
// Optional misaligned-access flagging is enabled with DMEM_MISALIGN_ERR_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int ADDR_W  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRe_i,
    input  logic        MemWr_i,
    input  logic [31:0] Adr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
`ifdef DMEM_MISALIGN_ERR_EN
    output logic        err_o,
`endif
    output logic        stall_o
);

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_in;
    logic [ADDR_W-1:0]   w_arr_idx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_data;
    logic [31:0]         w_rdata;
    op_e                 r_op;
    op_e                 w_op_in;
    op_e                 w_op_cur;
    logic                r_mis;
    logic                w_mis_in;
    logic                w_mis_cur;
    logic                r_ack;
    logic                w_req;
    logic                w_accept;
    logic                w_enter_done;
    logic                w_we;

    assign w_req    = MemRe_i | MemWr_i;
    assign w_accept = (r_state == ST_IDLE) & w_req;
    assign w_idx_in = Adr_i[ADDR_W+1:2];
    // A simultaneous load and store request is treated as a store.
    assign w_op_in  = MemWr_i ? OP_WR : OP_RD;

`ifdef DMEM_MISALIGN_ERR_EN
    logic w_unused_hi;
    assign w_unused_hi = ^Adr_i[31:ADDR_W+2];
    assign w_mis_in    = is_misaligned(Adr_i[1:0]);
    assign err_o       = r_mis;
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{Adr_i[31:ADDR_W+2], Adr_i[1:0]};
    assign w_mis_in      = 1'b0;
`endif

    // With LATENCY==1 the request goes IDLE->DONE, so live inputs are used in IDLE.
    assign w_op_cur  = (r_state == ST_IDLE) ? w_op_in  : r_op;
    assign w_mis_cur = (r_state == ST_IDLE) ? w_mis_in : r_mis;
    assign w_arr_idx = (r_state == ST_IDLE) ? w_idx_in : r_idx;

    assign w_enter_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);
    assign w_we         = (r_state == ST_DONE) && (r_op == OP_WR) && !r_mis;

    assign stall_o = w_accept | (r_state == ST_BUSY);
    assign ack_o   = r_ack;
    assign data_o  = r_data;

    // Next-state and counter logic.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_cnt_next   = LOAD_CNT;
                    w_next_state = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                w_cnt_next = (r_cnt != {CNT_W{1'b0}}) ? (r_cnt - CNT_W'(1)) : {CNT_W{1'b0}};
                if (r_cnt <= CNT_W'(1)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, request latches, error flag and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_idx   <= {ADDR_W{1'b0}};
            r_wdata <= 32'h0000_0000;
            r_op    <= OP_RD;
            r_mis   <= 1'b0;
            r_ack   <= 1'b0;
            r_data  <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_ack   <= (w_next_state == ST_DONE);
            if (w_accept) begin
                r_idx   <= w_idx_in;
                r_wdata <= data_i;
                r_op    <= w_op_in;
                r_mis   <= w_mis_in;
            end else if (r_state == ST_DONE) begin
                r_mis   <= 1'b0;
            end else begin
                r_mis   <= r_mis;
            end
            if (w_enter_done && (w_op_cur == OP_RD)) begin
                r_data <= w_mis_cur ? 32'h0000_0000 : w_rdata;
            end else begin
                r_data <= r_data;
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_we),
        .i_idx   (w_arr_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: one LATENCY=3 and one
// LATENCY=1 instance sharing clock and reset.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        re_a, we_a, re_b, we_b;
    logic [31:0] adr_a, din_a, adr_b, din_b;
    logic [31:0] dout_a, dout_b;
    logic        ack_a, ack_b, stall_a, stall_b;
    logic        err_a, err_b;

    int n_checks;
    int n_fail;

    data_mem_responder #(.LATENCY(3), .ADDR_W(8)) u_dut_a (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .MemRe_i (re_a),
        .MemWr_i (we_a),
        .Adr_i   (adr_a),
        .data_i  (din_a),
        .data_o  (dout_a),
        .ack_o   (ack_a),
`ifdef DMEM_MISALIGN_ERR_EN
        .err_o   (err_a),
`endif
        .stall_o (stall_a)
    );

    data_mem_responder #(.LATENCY(1), .ADDR_W(8)) u_dut_b (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .MemRe_i (re_b),
        .MemWr_i (we_b),
        .Adr_i   (adr_b),
        .data_i  (din_b),
        .data_o  (dout_b),
        .ack_o   (ack_b),
`ifdef DMEM_MISALIGN_ERR_EN
        .err_o   (err_b),
`endif
        .stall_o (stall_b)
    );

`ifndef DMEM_MISALIGN_ERR_EN
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel_b, input logic re, input logic we,
                         input logic [31:0] adr, input logic [31:0] din);
        if (sel_b) begin
            re_b = re; we_b = we; adr_b = adr; din_b = din;
        end else begin
            re_a = re; we_a = we; adr_a = adr; din_a = din;
        end
    endtask

    // Issues one request, checks stall/ack/err every cycle, returns data_o in the ack cycle.
    task automatic run_req(input string tag, input bit sel_b, input logic re, input logic we,
                           input logic [31:0] adr, input logic [31:0] din,
                           output logic [31:0] dout);
        int   lat;
        logic exp_err;
        lat = sel_b ? 1 : 3;
`ifdef DMEM_MISALIGN_ERR_EN
        exp_err = (adr[1:0] != 2'b00);
`else
        exp_err = 1'b0;
`endif
        @(posedge clk); #1;
        drive(sel_b, re, we, adr, din);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check_eq({tag, "_stall"}, {31'd0, sel_b ? stall_b : stall_a}, 32'd1);
            check_eq({tag, "_ack_early"}, {31'd0, sel_b ? ack_b : ack_a}, 32'd0);
            if (k > 0) begin
                check_eq({tag, "_err_busy"}, {31'd0, sel_b ? err_b : err_a}, {31'd0, exp_err});
            end
            @(posedge clk); #1;
        end
        drive(sel_b, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_eq({tag, "_stall_done"}, {31'd0, sel_b ? stall_b : stall_a}, 32'd0);
        check_eq({tag, "_ack"}, {31'd0, sel_b ? ack_b : ack_a}, 32'd1);
        check_eq({tag, "_err_done"}, {31'd0, sel_b ? err_b : err_a}, {31'd0, exp_err});
        dout = sel_b ? dout_b : dout_a;
    endtask

    initial begin
        logic [31:0] rd;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("rst_stall", {31'd0, stall_a}, 32'd0);
        check_eq("rst_ack", {31'd0, ack_a}, 32'd0);
        check_eq("rst_data", dout_a, 32'h0);
        check_eq("rst_err", {31'd0, err_a}, 32'd0);
        rst_n = 1'b1;

        // Store then load back on the 3-cycle instance.
        run_req("st10", 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd);
        check_eq("st10_data_hold", rd, 32'h0);
        run_req("ld10", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, rd);
        check_eq("ld10_data", rd, 32'hDEADBEEF);

        // Both requests high behaves as a store and leaves data_o alone.
        run_req("both20", 1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, rd);
        check_eq("both20_data_hold", rd, 32'hDEADBEEF);
        run_req("ld20", 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, rd);
        check_eq("ld20_data", rd, 32'hA5A5A5A5);

        // Address wrap: 0x400 aliases word 0.
        run_req("st400", 1'b0, 1'b0, 1'b1, 32'h400, 32'h1, rd);
        run_req("ld000", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, rd);
        check_eq("wrap_data", rd, 32'h1);

        // Reset during the BUSY cycle of a store drops it.
        run_req("st8", 1'b0, 1'b0, 1'b1, 32'h8, 32'h11112222, rd);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h8, 32'hFFFF0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        check_eq("abort_stall", {31'd0, stall_a}, 32'd0);
        check_eq("abort_data", dout_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("abort_no_ack", {31'd0, ack_a}, 32'd0);
        end
        run_req("ld8", 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, rd);
        check_eq("abort_prior_data", rd, 32'h11112222);

`ifdef DMEM_MISALIGN_ERR_EN
        // Misaligned store suppressed; misaligned load returns zero.
        run_req("mis_st", 1'b0, 1'b0, 1'b1, 32'h2, 32'h55, rd);
        run_req("mis_ld0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, rd);
        check_eq("mis_word0", rd, 32'h1);
        run_req("mis_ld2", 1'b0, 1'b1, 1'b0, 32'h2, 32'h0, rd);
        check_eq("mis_ld_zero", rd, 32'h0);
        @(negedge clk);
        check_eq("mis_err_clear", {31'd0, err_a}, 32'd0);
`endif

        // Single-cycle latency instance.
        run_req("b_st30", 1'b1, 1'b0, 1'b1, 32'h30, 32'h12345678, rd);
        run_req("b_ld30", 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, rd);
        check_eq("b_ld30_data", rd, 32'h12345678);
        run_req("b_ld10", 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, rd);
        check_eq("b_private_array", rd === 32'hDEADBEEF ? 32'd1 : 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
